ahb_lite_master_interface: RTL and testbench

AHB_LITE_MASTER_INTERFACE -- requirements
Module: ahb_lite_master_interface

---
 rtl/ahb_pkg.sv | 31 +++
 rtl/ahb_beat_counter.sv | 26 ++
 rtl/ahb_lite_master_interface.sv | 183 ++++++++++++++++++
 tb/tb_ahb_lite_master_interface.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings and master state codes for the ciphertext
// write-back master.
package ahb_pkg;

    localparam int AHB_BUS_SIZE = 32;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HBURST_SINGLE = 3'b000;
    localparam logic [2:0] HBURST_INCR4  = 3'b011;
    localparam logic [2:0] HSIZE_WORD    = 3'b010;

    // Index of the last beat of an INCR4 burst.
    localparam logic [1:0] LAST_BEAT = 2'd3;

    typedef logic [2:0] master_state_t;

    localparam master_state_t ST_IDLE      = 3'd0;
    localparam master_state_t ST_ADDR0     = 3'd1;
    localparam master_state_t ST_BEAT      = 3'd2;
    localparam master_state_t ST_LAST_DATA = 3'd3;
    localparam master_state_t ST_ERROR     = 3'd4;

    function automatic logic is_busy_state(input master_state_t s);
        return (s == ST_ADDR0) || (s == ST_BEAT) || (s == ST_LAST_DATA);
    endfunction

endpackage

// File: rtl/ahb_beat_counter.sv
// Two-bit beat counter for an INCR4 burst; flags the final beat.
module ahb_beat_counter
    import ahb_pkg::*;
(
    input  logic       clk,
    input  logic       srst,
    input  logic       clear,
    input  logic       enable,
    output logic [1:0] count,
    output logic       terminal
);

    logic [1:0] count_reg;

    always_ff @(posedge clk) begin
        if (srst || clear) begin
            count_reg <= 2'd0;
        end else if (enable) begin
            count_reg <= count_reg + 2'd1;
        end
    end

    assign count    = count_reg;
    assign terminal = (count_reg == LAST_BEAT);

endmodule

// File: rtl/ahb_lite_master_interface.sv
// AHB-Lite write master: drains 128-bit ciphertext blocks from a show-ahead
// FIFO and writes each one as an INCR4 word burst to a self-advancing address.
module ahb_lite_master_interface #(
    parameter int AHB_BUS_SIZE = ahb_pkg::AHB_BUS_SIZE
) (
    input  logic                      HCLK,
    input  logic                      HRESET,
    input  logic                      HREADY,
    input  logic                      HRESP,
    input  logic                      load_dest,
    input  logic [AHB_BUS_SIZE-1:0]   destination,
    input  logic                      fifo_empty,
    input  logic [4*AHB_BUS_SIZE-1:0] fifo_rdata,
    input  logic                      err_clear,
    output logic                      fifo_read,
    output logic [AHB_BUS_SIZE-1:0]   HADDR,
    output logic                      HWRITE,
    output logic [2:0]                HSIZE,
    output logic [2:0]                HBURST,
    output logic [1:0]                HTRANS,
    output logic [AHB_BUS_SIZE-1:0]   HWDATA,
    output logic                      busy,
    output logic                      block_done,
    output logic                      error
);

    import ahb_pkg::*;

    localparam int BLOCK_BITS = 4 * AHB_BUS_SIZE;
    localparam logic [AHB_BUS_SIZE-1:0] ALIGN_MASK   = {{(AHB_BUS_SIZE-4){1'b1}}, 4'b0000};
    localparam logic [AHB_BUS_SIZE-1:0] BLOCK_STRIDE = {{(AHB_BUS_SIZE-5){1'b0}}, 5'd16};

    master_state_t             state_reg;
    master_state_t             state_next;
    logic [AHB_BUS_SIZE-1:0]   dest_reg;
    logic                      dest_valid_reg;
    logic [BLOCK_BITS-1:0]     block_reg;
    logic                      block_done_reg;

    logic [1:0]                beat;
    logic                      beat_last;
    logic                      cnt_clear;
    logic                      cnt_enable;

    logic [AHB_BUS_SIZE-1:0]   words [4];
    logic [AHB_BUS_SIZE-1:0]   beat_offset;

    logic                      start;
    logic                      dest_load;
    logic                      bus_fault;
    logic                      block_complete;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_word
            assign words[gi] = block_reg[gi*AHB_BUS_SIZE +: AHB_BUS_SIZE];
        end
    endgenerate

    assign beat_offset = {{(AHB_BUS_SIZE-4){1'b0}}, beat, 2'b00};

    // A new destination always wins over starting a burst in the same cycle.
    assign dest_load = (state_reg == ST_IDLE) && load_dest;
    assign start     = (state_reg == ST_IDLE) && dest_valid_reg && !fifo_empty
                       && !load_dest && !HRESET;

    // Only BEAT and LAST_DATA carry one of our data phases; an error response
    // is recognised on its first (HREADY low) cycle.
    assign bus_fault = ((state_reg == ST_BEAT) || (state_reg == ST_LAST_DATA))
                       && HRESP && !HREADY;

    assign block_complete = (state_reg == ST_LAST_DATA) && HREADY;

    assign cnt_clear  = start || bus_fault;
    assign cnt_enable = HREADY && ((state_reg == ST_ADDR0) ||
                                   ((state_reg == ST_BEAT) && !beat_last));

    ahb_beat_counter u_beat_counter (
        .clk      (HCLK),
        .srst     (HRESET),
        .clear    (cnt_clear),
        .enable   (cnt_enable),
        .count    (beat),
        .terminal (beat_last)
    );

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    state_next = ST_ADDR0;
                end
            end
            ST_ADDR0: begin
                if (HREADY) begin
                    state_next = ST_BEAT;
                end
            end
            ST_BEAT: begin
                if (bus_fault) begin
                    state_next = ST_ERROR;
                end else if (HREADY && beat_last) begin
                    state_next = ST_LAST_DATA;
                end
            end
            ST_LAST_DATA: begin
                if (bus_fault) begin
                    state_next = ST_ERROR;
                end else if (HREADY) begin
                    state_next = ST_IDLE;
                end
            end
            ST_ERROR: begin
                if (err_clear) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state_reg      <= ST_IDLE;
            dest_reg       <= '0;
            dest_valid_reg <= 1'b0;
            block_reg      <= '0;
            block_done_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            block_done_reg <= block_complete;

            if (dest_load) begin
                dest_reg       <= destination & ALIGN_MASK;
                dest_valid_reg <= 1'b1;
            end else if (block_complete) begin
                dest_reg <= dest_reg + BLOCK_STRIDE;
            end

            // An errored block is dropped rather than retried.
            if (start) begin
                block_reg <= fifo_rdata;
            end else if (bus_fault) begin
                block_reg <= '0;
            end
        end
    end

    always_comb begin
        HTRANS = HTRANS_IDLE;
        HADDR  = '0;
        HWDATA = '0;
        case (state_reg)
            ST_ADDR0: begin
                HTRANS = HTRANS_NONSEQ;
                HADDR  = dest_reg;
            end
            ST_BEAT: begin
                HTRANS = HTRANS_SEQ;
                HADDR  = dest_reg + beat_offset;
                HWDATA = words[beat - 2'd1];
            end
            ST_LAST_DATA: begin
                HWDATA = words[LAST_BEAT];
            end
            default: begin
                HTRANS = HTRANS_IDLE;
            end
        endcase
    end

    assign busy       = is_busy_state(state_reg);
    assign HWRITE     = busy;
    assign HSIZE      = HSIZE_WORD;
    assign HBURST     = busy ? HBURST_INCR4 : HBURST_SINGLE;
    assign fifo_read  = start;
    assign block_done = block_done_reg;
    assign error      = (state_reg == ST_ERROR);

endmodule

// File: tb/tb_ahb_lite_master_interface.sv
// Scoreboard bench for the AHB-Lite write master: expected beats are queued as
// blocks are offered and matched against accepted address/data phases.
module tb_ahb_lite_master_interface;

    import ahb_pkg::*;

    logic         HCLK = 1'b0;
    logic         HRESET;
    logic         HREADY;
    logic         HRESP;
    logic         load_dest;
    logic [31:0]  destination;
    logic         fifo_empty;
    logic [127:0] fifo_rdata;
    logic         err_clear;
    logic         fifo_read;
    logic [31:0]  HADDR;
    logic         HWRITE;
    logic [2:0]   HSIZE;
    logic [2:0]   HBURST;
    logic [1:0]   HTRANS;
    logic [31:0]  HWDATA;
    logic         busy;
    logic         block_done;
    logic         error;

    typedef struct {
        logic [31:0] addr;
        logic [1:0]  trans;
        logic [31:0] data;
    } beat_t;

    beat_t        sb[$];
    logic [127:0] fq[$];

    int           checks = 0;
    int           errors = 0;
    int           rd_idx = 0;
    int           done_count = 0;
    int           cyc = 0;
    int           read_cyc = 0;
    int           done_cyc = 0;
    bit           pending = 1'b0;
    logic [31:0]  pending_addr;
    logic [31:0]  pending_data;
    logic [31:0]  exp_dest = 32'h0;
    bit           pop_req;

    always #5 HCLK = ~HCLK;

    ahb_lite_master_interface #(.AHB_BUS_SIZE(32)) dut (
        .HCLK        (HCLK),
        .HRESET      (HRESET),
        .HREADY      (HREADY),
        .HRESP       (HRESP),
        .load_dest   (load_dest),
        .destination (destination),
        .fifo_empty  (fifo_empty),
        .fifo_rdata  (fifo_rdata),
        .err_clear   (err_clear),
        .fifo_read   (fifo_read),
        .HADDR       (HADDR),
        .HWRITE      (HWRITE),
        .HSIZE       (HSIZE),
        .HBURST      (HBURST),
        .HTRANS      (HTRANS),
        .HWDATA      (HWDATA),
        .busy        (busy),
        .block_done  (block_done),
        .error       (error)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    // Runs on every falling edge: matches accepted phases against the queue.
    task automatic mon_step();
        beat_t b;
        cyc++;
        if (HRESET) begin
            pending = 1'b0;
            return;
        end
        if (fifo_read) read_cyc = cyc;
        if (block_done) begin
            done_count++;
            done_cyc = cyc;
        end
        if (pending && HREADY) begin
            if (!HRESP) begin
                chk("hwdata", 64'(HWDATA), 64'(pending_data));
                $display("beat addr=%08h data=%08h", pending_addr, HWDATA);
            end
            pending = 1'b0;
        end
        if (HTRANS[1] && HREADY) begin
            if (sb.size() == 0) begin
                chk("sb_underflow", 64'(sb.size()), 64'd1);
            end else begin
                b = sb.pop_front();
                chk("haddr", 64'(HADDR), 64'(b.addr));
                chk("htrans", 64'(HTRANS), 64'(b.trans));
                chk("hctrl", 64'({HWRITE, HSIZE, HBURST}), 64'({1'b1, HSIZE_WORD, HBURST_INCR4}));
                pending      = 1'b1;
                pending_addr = b.addr;
                pending_data = b.data;
            end
        end
    endtask

    task automatic push_expect(input logic [127:0] blk, input bit advance);
        beat_t b;
        for (int n = 0; n < 4; n++) begin
            b.addr  = exp_dest + 32'(4 * n);
            b.trans = (n == 0) ? HTRANS_NONSEQ : HTRANS_SEQ;
            b.data  = blk[32*n +: 32];
            sb.push_back(b);
        end
        if (advance) exp_dest = exp_dest + 32'd16;
    endtask

    task automatic push_block(input logic [127:0] blk, input bit advance);
        fq.push_back(blk);
        push_expect(blk, advance);
    endtask

    task automatic load_addr(input logic [31:0] a);
        load_dest   = 1'b1;
        destination = a;
        tick();
        load_dest   = 1'b0;
        exp_dest    = {a[31:4], 4'b0000};
    endtask

    task automatic wait_addr(input logic [31:0] a, input logic [1:0] t, input string tag);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (HADDR === a && HTRANS === t) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        chk({tag, "_reach"}, 64'(ok), 64'd1);
    endtask

    task automatic wait_drain(input string tag);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (sb.size() == 0 && !pending && busy === 1'b0 && rd_idx >= fq.size()) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        chk({tag, "_drain"}, 64'(ok), 64'd1);
        tick();
        tick();
    endtask

    initial begin
        logic [127:0] blk_spec;
        logic [127:0] blk_b;

        blk_spec = 128'h44444444_33333333_22222222_11111111;
        blk_b    = 128'h88888888_77777777_66666666_55555555;

        HRESET      = 1'b1;
        HREADY      = 1'b1;
        HRESP       = 1'b0;
        load_dest   = 1'b0;
        destination = 32'h0;
        err_clear   = 1'b0;
        fifo_empty  = 1'b1;
        fifo_rdata  = '0;

        fork
            forever begin
                @(negedge HCLK);
                mon_step();
            end
            forever begin
                @(negedge HCLK);
                pop_req = fifo_read && !HRESET;
                @(posedge HCLK);
                #2;
                if (pop_req) rd_idx++;
                fifo_empty = (rd_idx >= fq.size());
                fifo_rdata = fifo_empty ? 128'h0 : fq[rd_idx];
            end
        join_none

        // Reset values
        tick();
        tick();
        HRESET = 1'b0;
        chk("rst_htrans", 64'(HTRANS), 64'(HTRANS_IDLE));
        chk("rst_haddr", 64'(HADDR), 64'd0);
        chk("rst_hwdata", 64'(HWDATA), 64'd0);
        chk("rst_hwrite", 64'(HWRITE), 64'd0);
        chk("rst_hsize", 64'(HSIZE), 64'(HSIZE_WORD));
        chk("rst_hburst", 64'(HBURST), 64'(HBURST_SINGLE));
        chk("rst_fifo_read", 64'(fifo_read), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_block_done", 64'(block_done), 64'd0);
        chk("rst_error", 64'(error), 64'd0);

        // FIFO has data but no destination yet
        fq.push_back(blk_spec);
        repeat (4) tick();
        chk("nodest_reads", 64'(rd_idx), 64'd0);
        chk("nodest_busy", 64'(busy), 64'd0);

        // Single block at 0x1000, then the next one at 0x1010
        load_addr(32'h0000_1000);
        push_expect(blk_spec, 1'b1);
        wait_drain("single");
        chk("latency", 64'(done_cyc - read_cyc), 64'd6);
        chk("single_done", 64'(done_count), 64'd1);
        push_block(blk_b, 1'b1);
        wait_drain("second");
        chk("second_done", 64'(done_count), 64'd2);

        // Three wait states on beat 2
        load_addr(32'h0000_1000);
        push_block(blk_spec, 1'b1);
        wait_addr(32'h0000_1008, HTRANS_SEQ, "wait");
        HREADY = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("wait_haddr", 64'(HADDR), 64'h1008);
            chk("wait_hwdata", 64'(HWDATA), 64'h2222_2222);
            chk("wait_htrans", 64'(HTRANS), 64'(HTRANS_SEQ));
        end
        HREADY = 1'b1;
        wait_drain("wait");
        chk("wait_done", 64'(done_count), 64'd3);

        // ERROR response on the first data phase
        load_addr(32'h0000_1000);
        push_block(blk_b, 1'b0);
        wait_addr(32'h0000_1004, HTRANS_SEQ, "err");
        HRESP  = 1'b1;
        HREADY = 1'b0;
        tick();
        chk("err_htrans", 64'(HTRANS), 64'(HTRANS_IDLE));
        chk("err_flag", 64'(error), 64'd1);
        chk("err_busy", 64'(busy), 64'd0);
        HREADY = 1'b1;
        tick();
        HRESP = 1'b0;
        chk("err_abandon", 64'(sb.size()), 64'd3);
        sb.delete();
        tick();
        tick();
        chk("err_hold", 64'(error), 64'd1);
        chk("err_no_done", 64'(done_count), 64'd3);
        err_clear = 1'b1;
        tick();
        err_clear = 1'b0;
        chk("err_cleared", 64'(error), 64'd0);
        push_block(blk_spec, 1'b1);
        wait_drain("after_err");
        chk("after_err_done", 64'(done_count), 64'd4);

        // 32-bit wrap, with a load_dest during the burst that must be ignored
        load_addr(32'hFFFF_FFF5);
        push_block(blk_b, 1'b1);
        wait_addr(32'hFFFF_FFF4, HTRANS_SEQ, "wrap");
        load_dest   = 1'b1;
        destination = 32'h0000_5000;
        tick();
        load_dest   = 1'b0;
        push_block(blk_spec, 1'b1);
        wait_drain("wrap");
        chk("wrap_done", 64'(done_count), 64'd6);

        // Reset in the middle of a burst
        push_block(blk_b, 1'b1);
        wait_addr(32'h0000_0014, HTRANS_SEQ, "midrst");
        HRESET = 1'b1;
        tick();
        chk("midrst_htrans", 64'(HTRANS), 64'(HTRANS_IDLE));
        chk("midrst_haddr", 64'(HADDR), 64'd0);
        chk("midrst_busy", 64'(busy), 64'd0);
        HRESET = 1'b0;
        chk("midrst_abandon", 64'(sb.size()), 64'd3);
        sb.delete();
        fq.push_back(blk_spec);
        repeat (4) tick();
        chk("midrst_no_read", 64'(rd_idx), 64'(fq.size() - 1));
        load_addr(32'h0000_2000);
        push_expect(blk_spec, 1'b1);
        wait_drain("post_rst");
        chk("post_rst_done", 64'(done_count), 64'd7);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
